// File: rtl/store_queue_be.sv
// rtl/store_queue_be.sv - store validation, lane alignment and in-order FIFO drain to the data bus
module store_queue_be #(
    parameter int          DATA_W  = 32,
    parameter int          DEPTH   = 4,
    parameter logic [31:0] MEM_LO  = 32'h0000_0000,
    parameter logic [31:0] MEM_HI  = 32'h0000_2fff,
    parameter logic [31:0] IO_LO   = 32'h0000_7f00,
    parameter logic [31:0] IO_HI   = 32'h0000_7f1b,
    parameter logic [31:0] RO_MASK = 32'h0000_0f08
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                st_valid,
    input  logic [2:0]          st_type,
    input  logic [31:0]         st_addr,
    input  logic [DATA_W-1:0]   st_data,
    input  logic                st_ovf,
    output logic                st_ready,
    output logic                ades,
    output logic                mem_req,
    output logic [31:0]         mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    output logic                empty
);
    localparam int NB = DATA_W / 8;
    localparam int L  = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int AW = IW + 1;

    logic [3:0]        size;
    logic              type_bad;
    logic              misaligned, in_mem, in_io, read_only, bad;
    logic [L-1:0]      lane;
    logic [15:0]       be_wide;
    logic [NB-1:0]     new_be;
    logic [DATA_W-1:0] dmask, new_wdata;
    logic [31:0]       new_addr;
    logic              push, pop;

    logic [AW-1:0]     wr_ptr, rd_ptr, count;
    logic [31:0]       addr_q  [DEPTH];
    logic [NB-1:0]     be_q    [DEPTH];
    logic [DATA_W-1:0] wdata_q [DEPTH];

    always_comb begin
        size     = 4'd1;
        type_bad = 1'b0;
        case (st_type)
            3'd0: size = 4'd1;
            3'd1: size = 4'd1;
            3'd2: size = 4'd2;
            3'd3: size = 4'd4;
            3'd4: begin
                size     = 4'd8;
                type_bad = (DATA_W != 64);
            end
            default: type_bad = 1'b1;
        endcase
    end

    // Offset-from-base compares keep region checks to one unsigned compare each.
    assign misaligned = |(st_addr[3:0] & (size - 4'd1));
    assign in_mem     = (st_addr - MEM_LO) <= (MEM_HI - MEM_LO);
    assign in_io      = (st_addr - IO_LO) <= (IO_HI - IO_LO);
    assign read_only  = (st_addr & 32'h0000_0f0c) == RO_MASK;
    assign bad        = type_bad | misaligned | (!in_mem && !in_io) |
                        (in_io && (size != 4'd4)) | (in_io && read_only) | st_ovf;
    assign ades       = st_valid && (st_type != 3'd0) && bad;

    assign lane     = st_addr[L-1:0];
    assign be_wide  = ((16'd1 << size) - 16'd1) << lane;
    assign new_be   = be_wide[NB-1:0];
    assign new_addr = {st_addr[31:L], {L{1'b0}}};

    always_comb begin
        dmask = '0;
        for (int i = 0; i < NB; i++) begin
            dmask[8*i +: 8] = (i < int'(size)) ? 8'hff : 8'h00;
        end
    end
    assign new_wdata = (st_data & dmask) << {lane, 3'b000};

    assign st_ready = (count != AW'(DEPTH));
    assign mem_req  = (count != '0);
    assign empty    = (count == '0);
    assign push     = st_valid && (st_type != 3'd0) && !ades && st_ready;
    assign pop      = mem_req && mem_ack;

    assign mem_addr  = addr_q[rd_ptr[IW-1:0]];
    assign mem_be    = be_q[rd_ptr[IW-1:0]];
    assign mem_wdata = wdata_q[rd_ptr[IW-1:0]];

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                be_q[i]    <= '0;
                wdata_q[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_q[wr_ptr[IW-1:0]]  <= new_addr;
                be_q[wr_ptr[IW-1:0]]    <= new_be;
                wdata_q[wr_ptr[IW-1:0]] <= new_wdata;
                wr_ptr                  <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_store_queue_be.sv
// tb/tb_store_queue_be.sv - randomized and directed checks of store_queue_be against a queue model
module tb_store_queue_be;
    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, st_ovf, mem_ack;
    logic [2:0]  st_type;
    logic [31:0] st_addr, st_data;
    logic        st_ready, ades, mem_req, empty;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        b_valid, b_ovf, b_ack;
    logic [2:0]  b_type;
    logic [31:0] b_addr;
    logic [63:0] b_data;
    logic        b_ready, b_ades, b_req, b_empty;
    logic [31:0] b_maddr;
    logic [63:0] b_wdata;
    logic [7:0]  b_be;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];

    store_queue_be dut_a (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_type(st_type), .st_addr(st_addr),
        .st_data(st_data), .st_ovf(st_ovf), .st_ready(st_ready), .ades(ades), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .empty(empty)
    );

    store_queue_be #(.DATA_W(64)) dut_b (
        .clk(clk), .reset(reset), .st_valid(b_valid), .st_type(b_type), .st_addr(b_addr),
        .st_data(b_data), .st_ovf(b_ovf), .st_ready(b_ready), .ades(b_ades), .mem_req(b_req),
        .mem_addr(b_maddr), .mem_be(b_be), .mem_wdata(b_wdata), .mem_ack(b_ack), .empty(b_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ades(input int w, input bit v, input logic [2:0] t,
                                  input logic [31:0] a, input bit ovf);
        int sz;
        bit inm, inio;
        if (!v || t == 3'd0) return 1'b0;
        if (t > 3'd4 || (t == 3'd4 && w == 32)) return 1'b1;
        sz = 1 << (t - 3'd1);
        if (a % 32'(sz) != 0) return 1'b1;
        inm  = a <= 32'h2fff;
        inio = a >= 32'h7f00 && a <= 32'h7f1b;
        if (!inm && !inio) return 1'b1;
        if (inio && sz != 4) return 1'b1;
        if (inio && (a & 32'hf0c) == 32'hf08) return 1'b1;
        return ovf;
    endfunction

    function automatic ent_t m_entry(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        int sz, lane;
        logic [127:0] m, r;
        sz   = 1 << (t - 3'd1);
        lane = int'(a % 32'd4);
        e.a  = a - 32'(lane);
        e.be = 4'((((1 << sz) - 1) << lane) & 4'hf);
        m    = (128'h1 << (8 * sz)) - 128'h1;
        r    = ({96'h0, d} & m) << (8 * lane);
        e.d  = r[31:0];
        return e;
    endfunction

    // Compare process: mid-cycle check of both DUTs, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (model_on) begin
            bit exp_ades, do_push, do_pop;
            int n;
            n        = q.size();
            exp_ades = m_ades(32, st_valid, st_type, st_addr, st_ovf);
            chk("ades", ades, exp_ades);
            chk("st_ready", st_ready, n != 4);
            chk("mem_req", mem_req, n != 0);
            chk("empty", empty, n == 0);
            if (n != 0) begin
                chk("mem_addr", mem_addr, q[0].a);
                chk("mem_be", mem_be, q[0].be);
                chk("mem_wdata", mem_wdata, q[0].d);
            end
            chk("b_ades", b_ades, m_ades(64, b_valid, b_type, b_addr, b_ovf));
            do_push = st_valid && st_type != 3'd0 && !exp_ades && n != 4;
            do_pop  = n != 0 && mem_ack;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(m_entry(st_type, st_addr, st_data));
        end
    end

    task automatic setin(input bit v, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] d, input bit ovf, input bit ack);
        st_valid = v; st_type = t; st_addr = a; st_data = d; st_ovf = ovf; mem_ack = ack;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        setin(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20 && mem_req; i++) step();
        chk("drain_done", mem_req, 1'b0);
        mem_ack = 1'b0;
    endtask

    initial begin
        logic [2:0] types [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [2:0]  t;
        logic [31:0] a;
        int sz;

        reset = 1'b1;
        setin(0, 0, 0, 0, 0, 0);
        b_valid = 0; b_type = 0; b_addr = 0; b_data = 0; b_ovf = 0; b_ack = 0;
        #2;
        chk("rst_ready", st_ready, 1'b1);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_be", mem_be, 4'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        step();
        step();
        reset = 1'b0;
        model_on = 1'b1;

        setin(1, 3'd1, 32'h3, 32'h1234_56ab, 0, 0);
        #1 chk("sb_ades", ades, 1'b0);
        step();
        setin(1, 3'd2, 32'h1, 32'h5555, 0, 0);
        #1 chk("sb_be", mem_be, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hab00_0000);
        chk("sb_addr", mem_addr, 32'h0);
        chk("sh_mis_ades", ades, 1'b1);
        step();
        setin(1, 3'd3, 32'h7f08, 32'h1, 0, 0);
        #1 chk("sw_ro_ades", ades, 1'b1);
        step();
        setin(1, 3'd1, 32'h7f00, 32'h1, 0, 0);
        #1 chk("sb_io_ades", ades, 1'b1);
        step();
        setin(1, 3'd4, 32'h10, 32'h1, 0, 0);
        #1 chk("sd_w32_ades", ades, 1'b1);
        step();
        setin(1, 3'd3, 32'h7f04, 32'hdead_beef, 0, 1);
        #1 chk("sw_io_ades", ades, 1'b0);
        step();
        setin(0, 0, 0, 0, 0, 0);
        #1 chk("sw_io_be", mem_be, 4'b1111);
        chk("sw_io_addr", mem_addr, 32'h7f04);
        drain();

        b_valid = 1; b_type = 3'd4; b_addr = 32'h10; b_data = 64'h1122_3344_5566_7788;
        step();
        b_type = 3'd3; b_addr = 32'h14; b_data = 64'h0000_0000_cafe_babe; b_ack = 1;
        #1 chk("sd_be", b_be, 8'hff);
        chk("sd_wdata", b_wdata, 64'h1122_3344_5566_7788);
        chk("sd_addr", b_maddr, 32'h10);
        step();
        b_valid = 0;
        #1 chk("sw64_be", b_be, 8'hf0);
        chk("sw64_wdata", b_wdata, 64'hcafe_babe_0000_0000);
        chk("sw64_addr", b_maddr, 32'h10);

        for (int i = 0; i < 4; i++) begin
            setin(1, 3'd3, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 0, 0);
            step();
        end
        setin(1, 3'd3, 32'h110, 32'h1004, 0, 0);
        #1 chk("full_ready", st_ready, 1'b0);
        step();
        step();
        mem_ack = 1'b1;
        #1 chk("full_ack_ready", st_ready, 1'b0);
        step();
        mem_ack = 1'b0;
        #1 chk("after_pop_ready", st_ready, 1'b1);
        step();
        #1 chk("refull_ready", st_ready, 1'b0);
        setin(0, 0, 0, 0, 0, 1);
        step();
        step();
        step();
        #1 chk("held_store_head", mem_addr, 32'h110);
        drain();

        for (int i = 0; i < 9; i++) begin
            setin(1, 3'd3, 32'h300 + 32'(4 * i), 32'(i + 1), 0, 1);
            #1 chk("b2b_ready", st_ready, 1'b1);
            if (i > 0) chk("b2b_head", mem_wdata, 32'(i));
            step();
        end
        setin(0, 0, 0, 0, 0, 1);
        #1 chk("wrap_head", mem_wdata, 32'd9);
        drain();

        b_ack = 1;
        for (int c = 0; c < 1500; c++) begin
            t  = types[$urandom_range(0, 9)];
            sz = (t >= 3'd1 && t <= 3'd4) ? (1 << (t - 3'd1)) : 1;
            case ($urandom_range(0, 5))
                0, 1:    a = $urandom_range(0, 32'h2fff);
                2:       a = 32'h7f00 + $urandom_range(0, 27);
                3:       a = 32'h2ff8 + $urandom_range(0, 16);
                4:       a = 32'h7ef8 + $urandom_range(0, 48);
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
            setin($urandom_range(0, 9) < 7, t, a, $urandom, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1);
            b_valid = st_valid; b_type = t; b_addr = a; b_ovf = st_ovf;
            b_data  = {$urandom, $urandom};
            step();
        end
        b_valid = 0;
        drain();

        for (int i = 0; i < 3; i++) begin
            setin(1, 3'd3, 32'h400 + 32'(4 * i), 32'h77 + 32'(i), 0, 0);
            step();
        end
        setin(0, 0, 0, 0, 0, 0);
        model_on = 1'b0;
        #1 reset = 1'b1;
        #1 chk("async_rst_req", mem_req, 1'b0);
        chk("async_rst_empty", empty, 1'b1);
        chk("async_rst_ready", st_ready, 1'b1);
        chk("async_rst_addr", mem_addr, 32'h0);
        q.delete();
        reset = 1'b0;
        #1 model_on = 1'b1;
        step();
        setin(1, 3'd3, 32'h500, 32'h0bad_f00d, 0, 0);
        step();
        setin(0, 0, 0, 0, 0, 0);
        #1 chk("post_rst_req", mem_req, 1'b1);
        chk("post_rst_wdata", mem_wdata, 32'h0bad_f00d);
        drain();

        model_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
